// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding and frame constants.
package uart_pkg;

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      START = 4'b0010,
      DATA  = 4'b0100,
      STOP  = 4'b1000
   } tx_state_t;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/tx_engine.sv
// UART 8N1 transmit engine: pops bytes from a fall-through FIFO and shifts them
// out LSB first, each bit held for OSR oversample ticks.
module tx_engine
   import uart_pkg::*;
#(
   parameter int OSR = 16
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic                      osr_tick_i,
   input  logic                      tx_en_i,
   input  logic [UART_DATA_BITS-1:0] tx_fifo_data_i,
   input  logic                      tx_fifo_empty_i,
   output logic                      tx_fifo_ren_o,
   output logic                      transmit_bit_o,
   output logic                      tx_busy_o
);

   localparam int              CW       = $clog2(OSR);
   localparam logic [CW-1:0]   OSR_LAST = CW'(OSR - 1);
   localparam logic [2:0]      LAST_BIT = 3'(UART_DATA_BITS - 1);

   tx_state_t                 state;
   logic [CW-1:0]             osr_cntr;
   logic [2:0]                bit_cntr;
   logic [UART_DATA_BITS-1:0] shift_reg;
   logic                      launch;

   assign launch = tx_en_i && !tx_fifo_empty_i;

   // The tick on the entry edge is never counted: the counter only advances
   // in the frame states, and each bit ends on its OSR-th tick.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state          <= IDLE;
         transmit_bit_o <= UART_IDLE_LEVEL;
         tx_fifo_ren_o  <= 1'b0;
         tx_busy_o      <= 1'b0;
         osr_cntr       <= '0;
         bit_cntr       <= '0;
         shift_reg      <= '0;
      end else begin
         tx_fifo_ren_o <= 1'b0;
         case (state)
            IDLE: begin
               if (launch) begin
                  shift_reg      <= tx_fifo_data_i;
                  tx_fifo_ren_o  <= 1'b1;
                  transmit_bit_o <= 1'b0;
                  tx_busy_o      <= 1'b1;
                  osr_cntr       <= '0;
                  state          <= START;
               end else begin
                  transmit_bit_o <= UART_IDLE_LEVEL;
                  tx_busy_o      <= 1'b0;
               end
            end
            START, DATA, STOP: begin
               if (osr_tick_i) begin
                  if (osr_cntr != OSR_LAST) begin
                     osr_cntr <= osr_cntr + CW'(1);
                  end else begin
                     osr_cntr <= '0;
                     case (state)
                        START: begin
                           transmit_bit_o <= shift_reg[0];
                           bit_cntr       <= '0;
                           state          <= DATA;
                        end
                        DATA: begin
                           if (bit_cntr != LAST_BIT) begin
                              shift_reg      <= {1'b0, shift_reg[UART_DATA_BITS-1:1]};
                              transmit_bit_o <= shift_reg[1];
                              bit_cntr       <= bit_cntr + 3'd1;
                           end else begin
                              transmit_bit_o <= UART_IDLE_LEVEL;
                              state          <= STOP;
                           end
                        end
                        default: begin
                           // End of stop bit: chain straight into the next frame if possible.
                           if (launch) begin
                              shift_reg      <= tx_fifo_data_i;
                              tx_fifo_ren_o  <= 1'b1;
                              transmit_bit_o <= 1'b0;
                              state          <= START;
                           end else begin
                              transmit_bit_o <= UART_IDLE_LEVEL;
                              tx_busy_o      <= 1'b0;
                              state          <= IDLE;
                           end
                        end
                     endcase
                  end
               end
            end
            default: begin
               state          <= IDLE;
               transmit_bit_o <= UART_IDLE_LEVEL;
               tx_busy_o      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_engine.sv
// Self-checking bench for tx_engine: FIFO model, frame-level line checks and a
// mid-bit sampling receiver for loopback.
module tb_tx_engine;

   localparam int OSR = 16;

   logic       clk_i = 1'b0;
   logic       reset_n_i = 1'b0;
   logic       osr_tick_i = 1'b0;
   logic       tx_en_i = 1'b0;
   logic [7:0] tx_fifo_data_i = 8'h00;
   logic       tx_fifo_empty_i = 1'b1;
   logic       tx_fifo_ren_o;
   logic       transmit_bit_o;
   logic       tx_busy_o;

   int total = 0;
   int bad = 0;
   int ren_count = 0;
   int tick_period = 1;
   int tick_cnt = 0;
   int rx_err = 0;
   bit mon_on = 1'b0;
   byte unsigned fifo[$];
   byte unsigned rx_q[$];

   tx_engine #(.OSR(OSR)) dut (
      .clk_i           (clk_i),
      .reset_n_i       (reset_n_i),
      .osr_tick_i      (osr_tick_i),
      .tx_en_i         (tx_en_i),
      .tx_fifo_data_i  (tx_fifo_data_i),
      .tx_fifo_empty_i (tx_fifo_empty_i),
      .tx_fifo_ren_o   (tx_fifo_ren_o),
      .transmit_bit_o  (transmit_bit_o),
      .tx_busy_o       (tx_busy_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      tick_cnt = tick_cnt + 1;
      if (tick_cnt >= tick_period) tick_cnt = 0;
      osr_tick_i = (tick_cnt == 0);
   end

   task automatic fifo_refresh();
      tx_fifo_empty_i = (fifo.size() == 0);
      tx_fifo_data_i  = (fifo.size() != 0) ? fifo[0] : 8'h00;
   endtask

   task automatic push(input byte unsigned b);
      fifo.push_back(b);
      fifo_refresh();
   endtask

   // Fall-through FIFO model; a pop strobe against an empty FIFO is an error.
   always @(posedge clk_i) begin
      if (tx_fifo_ren_o === 1'b1) begin
         total++;
         if (fifo.size() == 0) begin
            bad++;
            $display("FAIL ren_on_empty: ren=1 while fifo size=0");
         end else begin
            void'(fifo.pop_front());
         end
         ren_count++;
         fifo_refresh();
      end
   end

   // Behavioural receiver: find start edge, sample each bit in its middle.
   initial begin
      forever begin
         @(negedge clk_i);
         if (mon_on && transmit_bit_o === 1'b0) begin
            byte unsigned d;
            logic st, sp;
            d = 8'h00;
            repeat (OSR/2) @(negedge clk_i);
            st = transmit_bit_o;
            for (int k = 0; k < 8; k++) begin
               repeat (OSR) @(negedge clk_i);
               d[k] = transmit_bit_o;
            end
            repeat (OSR) @(negedge clk_i);
            sp = transmit_bit_o;
            rx_q.push_back(d);
            if (st !== 1'b0 || sp !== 1'b1) rx_err++;
         end
      end
   end

   // Waits for the start bit then checks every clock of the 10 bits.
   task automatic expect_frame(input byte unsigned b, input int period, input string nm,
                               output int waited);
      int   blen;
      logic exp;
      int   bad_c;
      logic g_line, g_busy, g_ren;
      blen   = OSR * period;
      waited = 0;
      do begin
         @(negedge clk_i);
         waited++;
      end while (transmit_bit_o !== 1'b0 && waited < 8*blen + 64);
      total++;
      if (transmit_bit_o !== 1'b0) begin
         bad++;
         $display("FAIL %s start: line=%b after %0d clocks, required 0", nm, transmit_bit_o, waited);
         return;
      end
      for (int k = 0; k < 10; k++) begin
         exp   = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
         bad_c = -1;
         g_line = 1'b0; g_busy = 1'b0; g_ren = 1'b0;
         for (int c = 0; c < blen; c++) begin
            if (k != 0 || c != 0) @(negedge clk_i);
            if (bad_c < 0 && (transmit_bit_o !== exp || tx_busy_o !== 1'b1 ||
                              tx_fifo_ren_o !== (k == 0 && c == 0))) begin
               bad_c = c; g_line = transmit_bit_o; g_busy = tx_busy_o; g_ren = tx_fifo_ren_o;
            end
         end
         total++;
         if (bad_c >= 0) begin
            bad++;
            $display("FAIL %s bit%0d clk%0d: line=%b busy=%b ren=%b, required line=%b busy=1 ren=%b",
                     nm, k, bad_c, g_line, g_busy, g_ren, exp, (k == 0 && bad_c == 0));
         end
      end
   endtask

   task automatic check_idle(input string nm);
      @(negedge clk_i);
      total++;
      if (transmit_bit_o !== 1'b1 || tx_busy_o !== 1'b0) begin
         bad++;
         $display("FAIL %s idle: line=%b busy=%b, required line=1 busy=0", nm, transmit_bit_o, tx_busy_o);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_i);
      total++;
      if (transmit_bit_o !== 1'b1 || tx_busy_o !== 1'b0 || tx_fifo_ren_o !== 1'b0) begin
         bad++;
         $display("FAIL reset: line=%b busy=%b ren=%b, required 1/0/0", transmit_bit_o, tx_busy_o, tx_fifo_ren_o);
      end
      #1 reset_n_i = 1'b1;
      repeat (2) @(negedge clk_i);
   endtask

   task automatic test_single();
      int w, r0;
      r0 = ren_count;
      tick_period = 1;
      @(negedge clk_i); #1;
      push(8'hA5);
      tx_en_i = 1'b1;
      expect_frame(8'hA5, 1, "single", w);
      check_idle("single");
      total++;
      if (ren_count - r0 != 1) begin
         bad++;
         $display("FAIL single pops: got %0d, required 1", ren_count - r0);
      end
   endtask

   task automatic test_back_to_back();
      int w;
      @(negedge clk_i); #1;
      push(8'h00);
      push(8'hFF);
      expect_frame(8'h00, 1, "b2b_f1", w);
      expect_frame(8'hFF, 1, "b2b_f2", w);
      total++;
      if (w != 1) begin
         bad++;
         $display("FAIL b2b gap: %0d clocks to second start, required 1", w);
      end
      check_idle("b2b");
   endtask

   task automatic test_sparse();
      int w, g;
      tx_en_i = 1'b0;
      tick_period = 4;
      push(8'h3C);
      g = 0;
      do begin @(negedge clk_i); #1; g++; end while (osr_tick_i !== 1'b1 && g < 16);
      tx_en_i = 1'b1;
      expect_frame(8'h3C, 4, "sparse", w);
      check_idle("sparse");
      tick_period = 1;
   endtask

   task automatic test_enable();
      int w, r0, bad_c;
      byte unsigned b1, b2;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      tx_en_i = 1'b0;
      @(negedge clk_i); #1;
      push(b1);
      r0 = ren_count;
      bad_c = -1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk_i);
         if (bad_c < 0 && (transmit_bit_o !== 1'b1 || tx_busy_o !== 1'b0)) bad_c = c;
      end
      total++;
      if (bad_c >= 0 || ren_count != r0) begin
         bad++;
         $display("FAIL en_low: idle break at clk %0d, pops=%0d, required none", bad_c, ren_count - r0);
      end
      #1 push(b2);
      tx_en_i = 1'b1;
      fork
         expect_frame(b1, 1, "en_frame", w);
         begin
            repeat (3*OSR) @(negedge clk_i);
            #1 tx_en_i = 1'b0;
         end
      join
      total++;
      if (w != 1) begin
         bad++;
         $display("FAIL en_rise latency: %0d clocks, required 1", w);
      end
      repeat (2*OSR) check_idle("en_drop");
      total++;
      if (ren_count - r0 != 1 || fifo.size() != 1) begin
         bad++;
         $display("FAIL en_drop pops: got %0d fifo=%0d, required 1 and 1", ren_count - r0, fifo.size());
      end
      #1 tx_en_i = 1'b1;
      expect_frame(b2, 1, "en_drain", w);
      check_idle("en_drain");
   endtask

   task automatic test_reset_mid();
      int w, r0, g;
      r0 = ren_count;
      @(negedge clk_i); #1;
      push(8'h55);
      g = 0;
      do begin @(negedge clk_i); g++; end while (transmit_bit_o !== 1'b0 && g < 64);
      repeat (4*OSR) @(negedge clk_i);
      #2 reset_n_i = 1'b0;
      tx_en_i = 1'b0;
      #1;
      total++;
      if (transmit_bit_o !== 1'b1 || tx_busy_o !== 1'b0 || tx_fifo_ren_o !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: line=%b busy=%b ren=%b, required 1/0/0", transmit_bit_o, tx_busy_o, tx_fifo_ren_o);
      end
      @(negedge clk_i); #1 reset_n_i = 1'b1;
      repeat (5) @(negedge clk_i);
      total++;
      if (ren_count - r0 != 1 || fifo.size() != 0) begin
         bad++;
         $display("FAIL reset pops: got %0d fifo=%0d, required 1 and 0", ren_count - r0, fifo.size());
      end
      #1 push(8'h81);
      tx_en_i = 1'b1;
      expect_frame(8'h81, 1, "post_reset", w);
      check_idle("post_reset");
   endtask

   task automatic test_loopback();
      byte unsigned sent[$];
      byte unsigned b;
      int r0, g;
      rx_q.delete();
      rx_err = 0;
      r0 = ren_count;
      tick_period = 1;
      @(negedge clk_i); #1;
      mon_on = 1'b1;
      for (int i = 0; i < 256; i++) begin
         b = 8'($urandom);
         sent.push_back(b);
         push(b);
      end
      tx_en_i = 1'b1;
      g = 0;
      do begin @(negedge clk_i); g++; end
      while ((fifo.size() != 0 || tx_busy_o !== 1'b0) && g < 256*10*OSR + 500);
      total++;
      if (fifo.size() != 0 || tx_busy_o !== 1'b0) begin
         bad++;
         $display("FAIL loopback timeout: fifo=%0d busy=%b after %0d clocks", fifo.size(), tx_busy_o, g);
      end
      repeat (4) @(negedge clk_i);
      mon_on = 1'b0;
      total++;
      if (rx_q.size() != 256 || rx_err != 0 || ren_count - r0 != 256) begin
         bad++;
         $display("FAIL loopback count: frames=%0d framing_errs=%0d pops=%0d, required 256/0/256",
                  rx_q.size(), rx_err, ren_count - r0);
      end
      for (int i = 0; i < 256 && i < rx_q.size(); i++) begin
         total++;
         if (rx_q[i] !== sent[i]) begin
            bad++;
            $display("FAIL loopback byte%0d: got %02h, required %02h", i, rx_q[i], sent[i]);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_sparse();
      test_enable();
      test_reset_mid();
      test_loopback();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
